// File: rtl/mux_scan_sequencer_if.sv
// Valid/ready readout stream from the mux scan sequencer to its consumer.
interface mux_scan_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 6
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_idx,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_idx,
    input  out_last
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Burst readout sequencer: steps the word-select mux from a base index and
// streams each captured word with its index and a last-word tag.
module mux_scan_sequencer #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [IDXW-1:0]        base,
  input  logic [IDXW:0]          len,
  input  logic                   abort,
  output logic [IDXW-1:0]        sel,
  input  logic [WIDTH-1:0]       muxdata,
  mux_scan_sequencer_if.master   rd,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [IDXW:0] REM_ONE = (IDXW + 1)'(1);
  localparam logic [IDXW:0] REM_MAX = REM_ONE << IDXW;

  state_t           state_r, state_s;
  logic [IDXW-1:0]  sel_r, sel_s;
  logic [IDXW:0]    rem_r, rem_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [IDXW-1:0]  idx_r, idx_s;
  logic             valid_r, valid_s;
  logic             last_r, last_s;
  logic             done_r, done_s;
  logic             load_s;

  assign load_s       = !valid_r || rd.out_ready;
  assign sel          = sel_r;
  assign rd.out_valid = valid_r;
  assign rd.out_data  = data_r;
  assign rd.out_idx   = idx_r;
  assign rd.out_last  = last_r;
  assign busy         = (state_r == RUN) || (state_r == LAST);
  assign done         = done_r;

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    rem_s   = rem_r;
    data_s  = data_r;
    idx_s   = idx_r;
    valid_s = valid_r;
    last_s  = last_r;
    done_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (start && (len != '0)) begin
          sel_s   = base;
          rem_s   = (len > REM_MAX) ? REM_MAX : len;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
          rem_s   = '0;
        end else if (load_s) begin
          data_s  = muxdata;
          idx_s   = sel_r;
          last_s  = (rem_r == REM_ONE);
          valid_s = 1'b1;
          sel_s   = sel_r + IDXW'(1);
          rem_s   = rem_r - REM_ONE;
          state_s = (rem_r == REM_ONE) ? LAST : RUN;
        end else begin
          state_s = RUN;
        end
      end
      LAST: begin
        // Final word is already captured; only its handshake remains.
        if (abort) begin
          state_s = IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
          rem_s   = '0;
        end else if (valid_r && rd.out_ready) begin
          valid_s = 1'b0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = LAST;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
        rem_s   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      sel_r   <= '0;
      rem_r   <= '0;
      data_r  <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      rem_r   <= rem_s;
      data_r  <= data_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      done_r  <= done_s;
    end
  end

endmodule
